// File: rtl/instr_mem_loader_if.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_if
//   Bundles the byte-stream handshake and the instruction-memory write bus of
//   the program loader.
//
//   master : the loader (consumes bytes, drives memory writes)
//   slave  : the environment (byte source + instruction memory)
//
//   i_rx_data   [7:0]        incoming byte
//   i_rx_valid               i_rx_data valid
//   o_rx_ready               loader accepts a byte this cycle
//   o_mem_we                 instruction memory write strobe
//   o_mem_addr  [ADDR_W-1:0] word address of the write
//   o_mem_data  [31:0]       assembled instruction
// -----------------------------------------------------------------------------
interface instr_mem_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              o_rx_ready;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_data;

    modport master (
        input  i_rx_data,
        input  i_rx_valid,
        output o_rx_ready,
        output o_mem_we,
        output o_mem_addr,
        output o_mem_data
    );

    modport slave (
        output i_rx_data,
        output i_rx_valid,
        input  o_rx_ready,
        input  o_mem_we,
        input  o_mem_addr,
        input  o_mem_data
    );
endinterface

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//   Writer side of the instruction memory. Packs an incoming byte stream into
//   32-bit instructions, writes them to consecutive word addresses from 0 and
//   stops on HALT_WORD. The fetch stage is held frozen (o_pc_write=0) until a
//   complete program is in memory, then restarted from PC 0.
//
//   clk           system clock
//   rst           synchronous, active-high reset
//   i_start       start/restart a load (honoured in IDLE, DONE, ERR)
//   bus           byte handshake + memory write bus (master side)
//   o_pc_write    fetch-stage PC write enable
//   o_pc_reset    one-cycle pulse forcing the fetch PC to 0
//   o_busy        load in progress (RECV or WRITE)
//   o_done        program loaded, halt word written
//   o_error       memory filled without a halt word
//   o_word_count  words written in current/last load, halt word included
// -----------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int unsigned ADDR_W        = 10,
    parameter bit          BYTE_ORDER_BE = 1'b1,
    parameter logic [31:0] HALT_WORD     = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    instr_mem_loader_if.master  bus,
    output logic                o_pc_write,
    output logic                o_pc_reset,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error,
    output logic [ADDR_W:0]     o_word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q;
    logic [ADDR_W-1:0] word_addr_q;
    logic [31:0]       asm_q, asm_next;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_data_q;
    logic [ADDR_W:0]   word_count_q;
    logic              pc_reset_q;

    logic rx_ready, mem_we, pc_write, busy, done, error;
    logic accept, restart;

    assign accept  = bus.i_rx_valid && rx_ready;
    assign restart = i_start && (state_q inside {S_IDLE, S_DONE, S_ERR});

    // Shifting the new byte in from one end puts the first byte of a word at
    // [31:24] (big-endian) or [7:0] (little-endian) once all four are in.
    always_comb begin
        if (BYTE_ORDER_BE) asm_next = {asm_q[23:0], bus.i_rx_data};
        else               asm_next = {bus.i_rx_data, asm_q[31:8]};
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        rx_ready = 1'b0;
        mem_we   = 1'b0;
        pc_write = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) state_d = S_RECV;
            end
            S_RECV: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (bus.i_rx_valid && byte_cnt_q == 2'd3) state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                // Halt wins over a full memory: a halt at the last address is a
                // successful load.
                if (mem_data_q == HALT_WORD)       state_d = S_DONE;
                else if (mem_addr_q == LAST_ADDR)  state_d = S_ERR;
                else                               state_d = S_RECV;
            end
            S_DONE: begin
                pc_write = 1'b1;
                done     = 1'b1;
                if (i_start) state_d = S_RECV;
            end
            S_ERR: begin
                error = 1'b1;
                if (i_start) state_d = S_RECV;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: byte packing, addressing, write-bus holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q   <= '0;
            word_addr_q  <= '0;
            asm_q        <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            word_count_q <= '0;
            pc_reset_q   <= 1'b0;
        end else begin
            if (restart) begin
                byte_cnt_q   <= '0;
                word_addr_q  <= '0;
                asm_q        <= '0;
                word_count_q <= '0;
            end

            if (accept) begin
                asm_q      <= asm_next;
                byte_cnt_q <= byte_cnt_q + 2'd1;
                // Capture the full word and its address into the bus registers
                // so they stay stable through WRITE and hold afterwards.
                if (byte_cnt_q == 2'd3) begin
                    mem_data_q <= asm_next;
                    mem_addr_q <= word_addr_q;
                end
            end

            if (state_q == S_WRITE) begin
                word_count_q <= word_count_q + (ADDR_W+1)'(1);
                if (state_d == S_RECV) word_addr_q <= word_addr_q + ADDR_W'(1);
            end

            // High exactly during the first DONE cycle.
            pc_reset_q <= (state_q == S_WRITE) && (state_d == S_DONE);
        end
    end

    assign bus.o_rx_ready = rx_ready;
    assign bus.o_mem_we   = mem_we;
    assign bus.o_mem_addr = mem_addr_q;
    assign bus.o_mem_data = mem_data_q;

    assign o_pc_write   = pc_write;
    assign o_pc_reset   = pc_reset_q;
    assign o_busy       = busy;
    assign o_done       = done;
    assign o_error      = error;
    assign o_word_count = word_count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
//   Three loaders share one byte source: A (BE, 1K words), B (LE, 1K words),
//   C (BE, 4 words). i_start is routed to the loader selected by sel; the
//   others stay idle and never accept bytes. Expected writes are queued per
//   loader and popped by a monitor on every write strobe.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] rx_data;
    logic       rx_valid;
    int         sel;

    int total = 0;
    int bad   = 0;

    wr_t        exp_a[$], exp_b[$], exp_c[$];
    logic [7:0] prog_q[$];
    int         gap_q[$];
    int         waits_q[$];
    int         pcr_a = 0, pcr_b = 0, pcr_c = 0;

    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    instr_mem_loader_if #(.ADDR_W(10)) bus_a ();
    instr_mem_loader_if #(.ADDR_W(10)) bus_b ();
    instr_mem_loader_if #(.ADDR_W(2))  bus_c ();

    assign bus_a.i_rx_data = rx_data;  assign bus_a.i_rx_valid = rx_valid;
    assign bus_b.i_rx_data = rx_data;  assign bus_b.i_rx_valid = rx_valid;
    assign bus_c.i_rx_data = rx_data;  assign bus_c.i_rx_valid = rx_valid;

    logic pcw_a, pcr_o_a, busy_a, done_a, err_a;
    logic pcw_b, pcr_o_b, busy_b, done_b, err_b;
    logic pcw_c, pcr_o_c, busy_c, done_c, err_c;
    logic [10:0] wc_a, wc_b;
    logic [2:0]  wc_c;

    instr_mem_loader #(.ADDR_W(10), .BYTE_ORDER_BE(1'b1), .HALT_WORD(32'hFFFF_FFFF)) dut_a (
        .clk(clk), .rst(rst), .i_start(start && sel == 0), .bus(bus_a),
        .o_pc_write(pcw_a), .o_pc_reset(pcr_o_a), .o_busy(busy_a),
        .o_done(done_a), .o_error(err_a), .o_word_count(wc_a));

    instr_mem_loader #(.ADDR_W(10), .BYTE_ORDER_BE(1'b0), .HALT_WORD(32'hFFFF_FFFF)) dut_b (
        .clk(clk), .rst(rst), .i_start(start && sel == 1), .bus(bus_b),
        .o_pc_write(pcw_b), .o_pc_reset(pcr_o_b), .o_busy(busy_b),
        .o_done(done_b), .o_error(err_b), .o_word_count(wc_b));

    instr_mem_loader #(.ADDR_W(2), .BYTE_ORDER_BE(1'b1), .HALT_WORD(32'hFFFF_FFFF)) dut_c (
        .clk(clk), .rst(rst), .i_start(start && sel == 2), .bus(bus_c),
        .o_pc_write(pcw_c), .o_pc_reset(pcr_o_c), .o_busy(busy_c),
        .o_done(done_c), .o_error(err_c), .o_word_count(wc_c));

    // Outputs of the currently selected loader
    logic        ready_s, pcw_s, pcr_s, busy_s, done_s, err_s;
    logic [10:0] wc_s;
    always_comb begin
        ready_s = bus_a.o_rx_ready; pcw_s = pcw_a; pcr_s = pcr_o_a;
        busy_s = busy_a; done_s = done_a; err_s = err_a; wc_s = wc_a;
        if (sel == 1) begin
            ready_s = bus_b.o_rx_ready; pcw_s = pcw_b; pcr_s = pcr_o_b;
            busy_s = busy_b; done_s = done_b; err_s = err_b; wc_s = wc_b;
        end else if (sel == 2) begin
            ready_s = bus_c.o_rx_ready; pcw_s = pcw_c; pcr_s = pcr_o_c;
            busy_s = busy_c; done_s = done_c; err_s = err_c; wc_s = {8'd0, wc_c};
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic add_word(input logic [31:0] w, input bit be);
        for (int i = 0; i < 4; i++) begin
            if (be) prog_q.push_back(w[31-8*i -: 8]);
            else    prog_q.push_back(w[8*i +: 8]);
        end
    endtask

    task automatic expect_wr(input int s, input logic [9:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        if (s == 0)      exp_a.push_back(e);
        else if (s == 1) exp_b.push_back(e);
        else             exp_c.push_back(e);
    endtask

    // Sends prog_q, each byte preceded by gap_q idle cycles (0 if gap_q empty).
    // Records how many cycles each byte waited for o_rx_ready.
    task automatic send_prog();
        waits_q.delete();
        while (prog_q.size() > 0) begin
            logic [7:0] b;
            int g;
            int n;
            b = prog_q.pop_front();
            g = (gap_q.size() > 0) ? gap_q.pop_front() : 0;
            rx_valid = 1'b0;
            repeat (g) tick();
            rx_data  = b;
            rx_valid = 1'b1;
            n = 0;
            while (!ready_s && n < 20) begin
                tick();
                n++;
            end
            if (!ready_s) begin
                check("rx_ready_timeout", ready_s, 1);
                prog_q.delete();
                gap_q.delete();
            end else begin
                waits_q.push_back(n);
                tick();
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_end(input bit want_err, input string name);
        int n = 0;
        while (!(want_err ? err_s : done_s) && n < 100) begin
            tick();
            n++;
        end
        check({name, "_reached"}, want_err ? err_s : done_s, 1);
    endtask

    // Checks the first DONE cycle and the one after it.
    task automatic check_done(input string name, input int wc);
        wait_end(1'b0, name);
        check({name, "_pc_reset_pulse"}, pcr_s, 1);
        check({name, "_pc_write"}, pcw_s, 1);
        check({name, "_word_count"}, wc_s, wc);
        tick();
        check({name, "_pc_reset_one_cycle"}, pcr_s, 0);
        check({name, "_done_held"}, done_s, 1);
        check({name, "_busy_clear"}, busy_s, 0);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (bus_a.o_mem_we) begin
            check("a_ready_in_write", bus_a.o_rx_ready, 0);
            if (exp_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_write: got addr %h data %h expected none", bus_a.o_mem_addr, bus_a.o_mem_data);
            end else begin
                wr_t e;
                e = exp_a.pop_front();
                check("a_wr_addr", 32'(bus_a.o_mem_addr), 32'(e.addr));
                check("a_wr_data", bus_a.o_mem_data, e.data);
            end
        end
        if (pcr_o_a) pcr_a++;
    end

    always @(negedge clk) begin
        if (bus_b.o_mem_we) begin
            check("b_ready_in_write", bus_b.o_rx_ready, 0);
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_write: got addr %h data %h expected none", bus_b.o_mem_addr, bus_b.o_mem_data);
            end else begin
                wr_t e;
                e = exp_b.pop_front();
                check("b_wr_addr", 32'(bus_b.o_mem_addr), 32'(e.addr));
                check("b_wr_data", bus_b.o_mem_data, e.data);
            end
        end
        if (pcr_o_b) pcr_b++;
    end

    always @(negedge clk) begin
        if (bus_c.o_mem_we) begin
            check("c_ready_in_write", bus_c.o_rx_ready, 0);
            if (exp_c.size() == 0) begin
                total++; bad++;
                $display("FAIL c_unexpected_write: got addr %h data %h expected none", bus_c.o_mem_addr, bus_c.o_mem_data);
            end else begin
                wr_t e;
                e = exp_c.pop_front();
                check("c_wr_addr", 32'(bus_c.o_mem_addr), 32'(e.addr));
                check("c_wr_data", bus_c.o_mem_data, e.data);
            end
        end
        if (pcr_o_c) pcr_c++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; sel = 0;
        repeat (3) tick();

        // Reset state
        check("rst_mem_we", bus_a.o_mem_we, 0);
        check("rst_mem_addr", 32'(bus_a.o_mem_addr), 0);
        check("rst_mem_data", bus_a.o_mem_data, 0);
        check("rst_rx_ready", ready_s, 0);
        check("rst_pc_write", pcw_s, 0);
        check("rst_pc_reset", pcr_s, 0);
        check("rst_busy", busy_s, 0);
        check("rst_done", done_s, 0);
        check("rst_error", err_s, 0);
        check("rst_word_count", wc_s, 0);
        rst = 1'b0;
        tick();

        // 1: basic load, big-endian
        pulse_start();
        check("t1_busy", busy_s, 1);
        check("t1_pc_write_frozen", pcw_s, 0);
        expect_wr(0, 10'd0, 32'h2001_0005);
        expect_wr(0, 10'd1, 32'hFFFF_FFFF);
        add_word(32'h2001_0005, 1'b1);
        add_word(32'hFFFF_FFFF, 1'b1);
        send_prog();
        check_done("t1", 2);
        check("t1_pc_reset_count", pcr_a, 1);

        // 6: reload from DONE
        pulse_start();
        check("t6_pc_write_cleared", pcw_s, 0);
        check("t6_done_cleared", done_s, 0);
        check("t6_busy", busy_s, 1);
        check("t6_word_count_cleared", wc_s, 0);
        expect_wr(0, 10'd0, 32'h1234_5678);
        expect_wr(0, 10'd1, 32'hDEAD_BEEF);
        expect_wr(0, 10'd2, 32'hFFFF_FFFF);
        add_word(32'h1234_5678, 1'b1);
        add_word(32'hDEAD_BEEF, 1'b1);
        add_word(32'hFFFF_FFFF, 1'b1);
        send_prog();
        check_done("t6", 3);
        check("t6_pc_reset_count", pcr_a, 2);

        // 2: flow control; byte 4 is presented during the WRITE cycle
        pulse_start();
        expect_wr(0, 10'd0, 32'h2001_0005);
        expect_wr(0, 10'd1, 32'hFFFF_FFFF);
        add_word(32'h2001_0005, 1'b1);
        add_word(32'hFFFF_FFFF, 1'b1);
        gap_q = '{0, 3, 5, 1, 0, 2, 4, 0};
        send_prog();
        if (waits_q.size() == 8) begin
            check("t2_first_byte_no_wait", waits_q[0], 0);
            check("t2_gap_byte_no_wait", waits_q[2], 0);
            check("t2_held_byte_waits_write", waits_q[4], 1);
        end else begin
            check("t2_bytes_sent", waits_q.size(), 8);
        end
        check_done("t2", 2);
        check("t2_pc_reset_count", pcr_a, 3);

        // 5: reset after two bytes of word 0
        pulse_start();
        prog_q = '{8'hAA, 8'hBB};
        send_prog();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy_after_rst", busy_s, 0);
        check("t5_ready_after_rst", ready_s, 0);
        check("t5_word_count_after_rst", wc_s, 0);
        tick();
        pulse_start();
        expect_wr(0, 10'd0, 32'hCAFE_F00D);
        expect_wr(0, 10'd1, 32'hFFFF_FFFF);
        add_word(32'hCAFE_F00D, 1'b1);
        add_word(32'hFFFF_FFFF, 1'b1);
        send_prog();
        check_done("t5", 2);
        check("t5_pc_reset_count", pcr_a, 4);

        // 3: little-endian loader
        sel = 1;
        pulse_start();
        expect_wr(1, 10'd0, 32'h2001_0005);
        expect_wr(1, 10'd1, 32'hFFFF_FFFF);
        prog_q = '{8'h05, 8'h00, 8'h01, 8'h20, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_prog();
        check_done("t3", 2);
        check("t3_pc_reset_count", pcr_b, 1);

        // 4: memory full without halt (4-word memory)
        sel = 2;
        pulse_start();
        for (int i = 1; i <= 4; i++) begin
            expect_wr(2, 10'(i - 1), 32'(i));
            add_word(32'(i), 1'b1);
        end
        send_prog();
        wait_end(1'b1, "t4");
        check("t4_pc_write", pcw_s, 0);
        check("t4_done", done_s, 0);
        check("t4_word_count", wc_s, 4);
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_no_ready_in_err", ready_s, 0);
            tick();
        end
        rx_valid = 1'b0;
        check("t4_error_held", err_s, 1);
        check("t4_pc_reset_count", pcr_c, 0);

        // Restart from ERR; halt at the last address; i_start with a byte in RECV
        pulse_start();
        check("t4r_error_cleared", err_s, 0);
        check("t4r_busy", busy_s, 1);
        expect_wr(2, 10'd0, 32'h1111_1111);
        expect_wr(2, 10'd1, 32'h2222_2222);
        expect_wr(2, 10'd2, 32'h3333_3333);
        expect_wr(2, 10'd3, 32'hFFFF_FFFF);
        add_word(32'h1111_1111, 1'b1);
        prog_q.push_back(8'h22);
        send_prog();
        start = 1'b1;
        prog_q.push_back(8'h22);
        send_prog();
        start = 1'b0;
        prog_q = '{8'h22, 8'h22};
        add_word(32'h3333_3333, 1'b1);
        add_word(32'hFFFF_FFFF, 1'b1);
        send_prog();
        check_done("t4r", 4);
        check("t4r_error", err_s, 0);
        check("t4r_pc_reset_count", pcr_c, 1);

        repeat (3) tick();
        check("end_exp_a_empty", exp_a.size(), 0);
        check("end_exp_b_empty", exp_b.size(), 0);
        check("end_exp_c_empty", exp_c.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
